// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per register and flags RAW and capacity hazards at decode.
// Latency: stall/issue_ack are combinational (0 cycles); pend, busy, wb_err, stall_cnt update on the next edge.
// Backpressure: stall holds the instruction in decode; issue_ack is raised only with no hazard and no flush.
module reg_scoreboard #(
  parameter int BYPASS  = 1,
  parameter int MAXPEND = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [2:0]  issue_rreg1,
  input  logic [2:0]  issue_rreg2,
  input  logic        issue_use1,
  input  logic        issue_use2,
  input  logic        issue_we,
  input  logic [2:0]  issue_wreg,
  input  logic        wb_valid,
  input  logic [2:0]  wb_wreg,
  input  logic        flush,
  output logic        stall,
  output logic        issue_ack,
  output logic        busy,
  output logic        wb_err,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] MAXP = 2'(MAXPEND);

  logic [1:0] pend     [8];
  logic [1:0] pend_nxt [8];
  logic [7:0] inc_v;
  logic [7:0] dec_v;
  logic       raw1;
  logic       raw2;
  logic       cap_hz;
  logic       wb_zero;
  logic       busy_nxt;

  // Hazard detection against the current pending counts; a retiring last write may be bypassed.
  always_comb begin
    raw1 = issue_use1 && (pend[issue_rreg1] != 2'd0);
    if ((BYPASS != 0) && wb_valid && (wb_wreg == issue_rreg1) && (pend[issue_rreg1] == 2'd1))
      raw1 = 1'b0;
    raw2 = issue_use2 && (pend[issue_rreg2] != 2'd0);
    if ((BYPASS != 0) && wb_valid && (wb_wreg == issue_rreg2) && (pend[issue_rreg2] == 2'd1))
      raw2 = 1'b0;
    cap_hz = issue_we && (pend[issue_wreg] == MAXP) && !(wb_valid && (wb_wreg == issue_wreg));
  end

  assign stall     = issue_valid && (raw1 || raw2 || cap_hz);
  assign issue_ack = issue_valid && !stall && !flush;
  assign wb_zero   = wb_valid && (pend[wb_wreg] == 2'd0);

  // Next pending counts: flush clears everything, a same-register issue and retire cancel out.
  always_comb begin
    inc_v    = '0;
    dec_v    = '0;
    busy_nxt = 1'b0;
    if (issue_ack && issue_we)
      inc_v[issue_wreg] = 1'b1;
    if (wb_valid && (pend[wb_wreg] != 2'd0))
      dec_v[wb_wreg] = 1'b1;
    for (int r = 0; r < 8; r++) begin
      pend_nxt[r] = pend[r];
      if (flush)
        pend_nxt[r] = 2'd0;
      else if (inc_v[r] && !dec_v[r] && (pend[r] != MAXP))
        pend_nxt[r] = pend[r] + 2'd1;
      else if (dec_v[r] && !inc_v[r])
        pend_nxt[r] = pend[r] - 2'd1;
      busy_nxt = busy_nxt | (pend_nxt[r] != 2'd0);
    end
  end

  // Pending counters and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 8; r++) pend[r] <= 2'd0;
      busy <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) pend[r] <= pend_nxt[r];
      busy <= busy_nxt;
    end
  end

  // Sticky error for a writeback that finds nothing pending; flush does not mask it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         wb_err <= 1'b0;
    else if (wb_zero) wb_err <= 1'b1;
  end

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= 16'd0;
    else if (issue_valid && stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios followed by random traffic against a pending-count model.
// Latency: combinational outputs checked 1 time unit after inputs change, registered ones 1 unit after the edge.
// Backpressure: the model predicts stall/ack each cycle; inputs are not held, so every cycle is independent.
module tb_reg_scoreboard;

  localparam int BYPASS  = 1;
  localparam int MAXPEND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_rreg1;
  logic [2:0]  issue_rreg2;
  logic        issue_use1;
  logic        issue_use2;
  logic        issue_we;
  logic [2:0]  issue_wreg;
  logic        wb_valid;
  logic [2:0]  wb_wreg;
  logic        flush;
  logic        stall;
  logic        issue_ack;
  logic        busy;
  logic        wb_err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: in-flight write count per register plus the observable flags.
  int pm [8];
  bit m_err;
  int m_scnt;
  bit e_stall;
  bit e_ack;

  reg_scoreboard #(.BYPASS(BYPASS), .MAXPEND(MAXPEND)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rreg1(issue_rreg1), .issue_rreg2(issue_rreg2),
    .issue_use1(issue_use1), .issue_use2(issue_use2), .issue_we(issue_we), .issue_wreg(issue_wreg),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .flush(flush),
    .stall(stall), .issue_ack(issue_ack), .busy(busy), .wb_err(wb_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_raw(input bit use_, input int rr);
    if (!use_ || pm[rr] == 0) return 1'b0;
    if (BYPASS == 1 && wb_valid && int'(wb_wreg) == rr && pm[rr] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit cap;
    cap = issue_we && pm[issue_wreg] == MAXPEND && !(wb_valid && wb_wreg == issue_wreg);
    return issue_valid && (m_raw(issue_use1, int'(issue_rreg1)) || m_raw(issue_use2, int'(issue_rreg2)) || cap);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 8; r++) pm[r] = 0;
    m_err  = 1'b0;
    m_scnt = 0;
  endtask

  task automatic drive(input bit iv, input int r1, input bit u1, input int r2, input bit u2,
                       input bit we, input int wr, input bit wbv, input int wbr, input bit fl);
    issue_valid = iv;
    issue_rreg1 = 3'(r1);
    issue_use1  = u1;
    issue_rreg2 = 3'(r2);
    issue_use2  = u2;
    issue_we    = we;
    issue_wreg  = 3'(wr);
    wb_valid    = wbv;
    wb_wreg     = 3'(wbr);
    flush       = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Let combinational outputs settle and compare them with the model's prediction.
  task automatic step_comb(input string tag);
    #1;
    e_stall = m_stall();
    e_ack   = issue_valid && !e_stall && !flush;
    chk($sformatf("%s.stall", tag), stall, e_stall);
    chk($sformatf("%s.ack", tag), issue_ack, e_ack);
  endtask

  // Clock one edge, advance the model, then compare the registered state.
  task automatic step_clk(input string tag);
    bit dec;
    bit any;
    @(posedge clk);
    if (wb_valid && pm[wb_wreg] == 0) m_err = 1'b1;
    if (issue_valid && e_stall) m_scnt = (m_scnt == 65535) ? 65535 : m_scnt + 1;
    if (flush) begin
      for (int r = 0; r < 8; r++) pm[r] = 0;
    end else begin
      dec = wb_valid && pm[wb_wreg] > 0;
      if (e_ack && issue_we) pm[issue_wreg] = pm[issue_wreg] + 1;
      if (dec) pm[wb_wreg] = pm[wb_wreg] - 1;
    end
    #1;
    any = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (pm[r] != 0) any = 1'b1;
      chk($sformatf("%s.pend%0d", tag, r), 32'(dut.pend[r]), pm[r]);
    end
    chk($sformatf("%s.busy", tag), busy, any);
    chk($sformatf("%s.wb_err", tag), wb_err, m_err);
    chk($sformatf("%s.stall_cnt", tag), stall_cnt, m_scnt);
  endtask

  task automatic step(input string tag);
    step_comb(tag);
    step_clk(tag);
  endtask

  initial begin
    int wbr;
    int cand [$];

    // Reset state, and combinational outputs computed on the cleared state while held in reset.
    idle();
    rst = 1'b0;
    m_reset();
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.wb_err", wb_err, 0);
    chk("rst.stall_cnt", stall_cnt, 0);
    drive(1, 3, 1, 4, 1, 1, 3, 0, 0, 0);
    #1;
    chk("rst.stall", stall, 0);
    chk("rst.ack", issue_ack, 1);
    idle();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Write r3, then a reader of r3 stalls until the writeback bypasses it.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); step("raw.wr3");
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); step_comb("raw.use3");
    chk("raw.stall_const", stall, 1);
    step_clk("raw.use3");
    chk("raw.cnt_const", stall_cnt, 1);
    drive(1, 3, 1, 0, 0, 0, 0, 1, 3, 0); step_comb("raw.bypass");
    chk("raw.bypass_stall", stall, 0);
    chk("raw.bypass_ack", issue_ack, 1);
    step_clk("raw.bypass");

    // Capacity: three writes to r5 fill it, a fourth stalls unless r5 retires in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); step($sformatf("cap.wr%0d", i));
    end
    chk("cap.pend5_full", 32'(dut.pend[5]), 3);
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); step_comb("cap.fourth");
    chk("cap.fourth_stall", stall, 1);
    step_clk("cap.fourth");
    drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0); step_comb("cap.fourth_wb");
    chk("cap.fourth_wb_ack", issue_ack, 1);
    step_clk("cap.fourth_wb");
    chk("cap.pend5_held", 32'(dut.pend[5]), 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0); step($sformatf("cap.drain%0d", i));
    end

    // Issue and writeback to r2 in the same cycle leave its count unchanged.
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); step("same.wr2");
    drive(1, 0, 0, 0, 0, 1, 2, 1, 2, 0); step("same.wr2wb2");
    chk("same.pend2", 32'(dut.pend[2]), 1);
    chk("same.busy", busy, 1);

    // Flush wins over issue: no ack, all counters clear.
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step("fl.wr1a");
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); step("fl.wr1b");
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); step("fl.wr6");
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 1); step_comb("fl.flush");
    chk("fl.ack_const", issue_ack, 0);
    step_clk("fl.flush");
    chk("fl.busy_const", busy, 0);

    // Writeback to r7 with nothing pending sets a sticky error and does not underflow.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step("err.wb7");
    chk("err.const", wb_err, 1);
    idle(); step("err.hold1");
    idle(); step("err.hold2");
    chk("err.pend7", 32'(dut.pend[7]), 0);

    // Build pend[4]=1 and stall_cnt=5 from scratch, then reset asynchronously between edges.
    #2; rst = 1'b0; #1; m_reset(); #2; rst = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); step("ar.wr4");
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0); step($sformatf("ar.st%0d", i));
    end
    chk("ar.cnt5", stall_cnt, 5);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0); step("ar.err");
    idle();
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    chk("ar.busy", busy, 0);
    chk("ar.wb_err", wb_err, 0);
    chk("ar.stall_cnt", stall_cnt, 0);
    chk("ar.pend4", 32'(dut.pend[4]), 0);
    #2;
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); step("ar.first");

    // Random traffic; writebacks mostly target registers that have something pending.
    for (int n = 0; n < 400; n++) begin
      cand.delete();
      for (int r = 0; r < 8; r++) if (pm[r] != 0) cand.push_back(r);
      if (cand.size() != 0 && $urandom_range(0, 19) != 0)
        wbr = cand[$urandom_range(0, cand.size() - 1)];
      else
        wbr = $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, wbr,
            $urandom_range(0, 24) == 0);
      step($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter BYPASS, default 1; 1 = a same-cycle writeback that retires the last pending write to a source register clears that hazard combinationally.
REQ-002 Parameter MAXPEND, default 3, legal 1..3; maximum in-flight writes tracked per register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 issue_valid  input  1  decode stage presents an instruction.
REQ-006 issue_rreg1, issue_rreg2  input  3 each  source register addresses.
REQ-007 issue_use1, issue_use2  input  1 each  source operand actually read.
REQ-008 issue_we  input  1  instruction writes a register.
REQ-009 issue_wreg  input  3  destination register address.
REQ-010 wb_valid  input  1  writeback retires one write this cycle.
REQ-011 wb_wreg  input  3  register being written back.
REQ-012 flush  input  1  squash all in-flight writes.
REQ-013 stall  output  1  combinational; instruction must be held in decode.
REQ-014 issue_ack  output  1  combinational; issue_valid && !stall && !flush.
REQ-015 busy  output  1  registered; any pending count nonzero.
REQ-016 wb_err  output  1  registered, sticky; writeback to a register with zero pending.
REQ-017 stall_cnt  output  16  registered; cycles with issue_valid && stall, saturating at 16'hFFFF.

Function
REQ-018 Eight 2-bit pending counters pend[0..7], one per register, including r0.
REQ-019 RAW hazard: source i (i = 1, 2) hazards when issue_use_i && pend[issue_rreg_i] != 0, unless BYPASS=1 && wb_valid && wb_wreg == issue_rreg_i && pend[issue_rreg_i] == 1.
REQ-020 Capacity hazard: issue_we && pend[issue_wreg] == MAXPEND, unless wb_valid && wb_wreg == issue_wreg in the same cycle.
REQ-021 stall = issue_valid && (RAW1 || RAW2 || capacity hazard); stall = 0 when issue_valid = 0.
REQ-022 Issue accepted = issue_ack; on accept with issue_we, pend[issue_wreg] increments.
REQ-023 Writeback with wb_valid and pend[wb_wreg] != 0: pend[wb_wreg] decrements.
REQ-024 Writeback with wb_valid and pend[wb_wreg] == 0: no counter change; wb_err set to 1 next cycle, held until reset.
REQ-025 Accepted issue and valid writeback to the same register in one cycle: net counter unchanged.
REQ-026 flush has priority over issue and writeback: all pend cleared next cycle; issue_ack = 0 that cycle; a same-cycle zero-pending writeback still sets wb_err.
REQ-027 busy next cycle = OR over next-state pend values.
REQ-028 stall_cnt increments when issue_valid && stall, independent of flush; holds at 16'hFFFF.
REQ-029 Counters never wrap: increment only when below MAXPEND, decrement only when nonzero.
REQ-030 Latency: hazard detection and ack have zero-cycle latency; counter effects are visible to the next cycle's hazard check.

Reset
REQ-031 rst low: immediately pend = 0, busy = 0, wb_err = 0, stall_cnt = 0, regardless of clk.
REQ-032 Reset asserted mid-operation discards all in-flight state; the first edge after rst rises is a normal cycle.
REQ-033 During reset, stall and issue_ack follow their combinational definitions on the cleared state.

Verification
REQ-034 Issue r3 write (issue_we, wreg=3); next cycle issue use1 rreg1=3 -> stall=1, stall_cnt increments; wb r3 -> stall=0 same cycle (BYPASS=1), issue_ack=1.
REQ-035 Three issues writing r5 with no writeback, then a fourth -> first three acked with pend[5]=3; fourth stalls; with wb r5 in the same cycle the fourth is acked and pend[5] stays 3.
REQ-036 Issue and writeback both target r2 with pend[2]=1 -> pend[2]=1 next cycle, busy=1.
REQ-037 pend[1]=2 and pend[6]=1, assert flush with issue_valid -> issue_ack=0; next cycle all pend=0, busy=0.
REQ-038 wb_valid with wb_wreg=7 and pend[7]=0 -> wb_err=1 next cycle and held; no counter underflow.
REQ-039 Pulse rst low asynchronously between edges while pend nonzero and stall_cnt=5 -> all outputs cleared immediately, before the next clk edge.
